// File: rtl/score_result_collector_if.sv
// Lane result inputs, registered output stream and max/status outputs of the result collector.
// master = score bank / host side, slave = collector.
interface score_result_collector_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int LANES       = 4,
  parameter int LANE_W      = $clog2(LANES)
);
  logic [LANES*SCORE_WIDTH-1:0] res_in;
  logic [LANES*ID_WIDTH-1:0]    id_in;
  logic [LANES-1:0]             vld_in;
  logic                         clear_max;
  logic [SCORE_WIDTH-1:0]       out_score;
  logic [ID_WIDTH-1:0]          out_id;
  logic [LANE_W-1:0]            out_lane;
  logic                         out_valid;
  logic                         out_ready;
  logic [SCORE_WIDTH-1:0]       max_score;
  logic [ID_WIDTH-1:0]          max_id;
  logic                         max_valid;
  logic                         overflow;
  logic                         busy;

  modport master (
    output res_in, id_in, vld_in, clear_max, out_ready,
    input  out_score, out_id, out_lane, out_valid,
    input  max_score, max_id, max_valid, overflow, busy
  );

  modport slave (
    input  res_in, id_in, vld_in, clear_max, out_ready,
    output out_score, out_id, out_lane, out_valid,
    output max_score, max_id, max_valid, overflow, busy
  );
endinterface

// File: rtl/score_result_collector.sv
// One-deep hold per lane, round-robin onto a registered valid/ready stream (2-cycle min latency,
// 1/cycle throughput; out_* frozen while stalled, a lane result arriving into a still-full hold is dropped).
module score_result_collector #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int LANES       = 4,
  parameter int LANE_W      = $clog2(LANES)
) (
  input logic                     clk,
  input logic                     rst,
  score_result_collector_if.slave sr
);

  typedef struct packed {
    logic [SCORE_WIDTH-1:0] score;
    logic [ID_WIDTH-1:0]    id;
  } entry_t;

  entry_t              lane_in [LANES];
  entry_t              hold    [LANES];
  logic [LANES-1:0]    hold_full;
  logic [LANE_W-1:0]   rr_ptr;
  entry_t              out_q;
  logic [LANE_W-1:0]   out_lane_q;
  logic                out_valid_q;
  entry_t              max_q;
  logic                max_valid_q;
  logic                overflow_q;

  logic                slot_free;
  logic                gnt_vld;
  logic                do_grant;
  logic [LANE_W-1:0]   gnt;
  logic [LANE_W-1:0]   gnt_next;
  logic [LANE_W-1:0]   idx;
  logic [LANES-1:0]    gnt_mask;
  logic [LANES-1:0]    acc;
  logic [LANES-1:0]    drop;
  logic                cand_vld;
  entry_t              cand;
  logic                base_valid;
  logic                max_load;

  always_comb begin
    slot_free = !out_valid_q || sr.out_ready;
    gnt_vld   = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = LANE_W'((int'(rr_ptr) + k) % LANES);
      if (!gnt_vld && hold_full[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
    do_grant = slot_free && gnt_vld;
    gnt_next = LANE_W'((int'(gnt) + 1) % LANES);

    // A lane emptied by this edge's grant can take a new result on the same edge.
    gnt_mask = '0;
    acc      = '0;
    drop     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_in[i].score = sr.res_in[i*SCORE_WIDTH +: SCORE_WIDTH];
      lane_in[i].id    = sr.id_in[i*ID_WIDTH +: ID_WIDTH];
      gnt_mask[i]      = do_grant && (gnt == LANE_W'(i));
      acc[i]           = sr.vld_in[i] && (!hold_full[i] || gnt_mask[i]);
      drop[i]          = sr.vld_in[i] && hold_full[i] && !gnt_mask[i];
    end

    // Strict compare in ascending lane order leaves ties with the lowest lane.
    cand_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (acc[i] && (!cand_vld || lane_in[i].score > cand.score)) begin
        cand_vld = 1'b1;
        cand     = lane_in[i];
      end
    end
    base_valid = max_valid_q && !sr.clear_max;
    max_load   = cand_vld && (!base_valid || cand.score > max_q.score);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) hold[i] <= '0;
      hold_full   <= '0;
      rr_ptr      <= '0;
      out_q       <= '0;
      out_lane_q  <= '0;
      out_valid_q <= 1'b0;
      max_q       <= '0;
      max_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (do_grant) begin
        out_q       <= hold[gnt];
        out_lane_q  <= gnt;
        out_valid_q <= 1'b1;
        rr_ptr      <= gnt_next;
      end else if (slot_free) begin
        out_valid_q <= 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (acc[i]) hold[i] <= lane_in[i];
      end
      hold_full <= (hold_full & ~gnt_mask) | acc;
      if (|drop) overflow_q <= 1'b1;
      if (max_load) max_q <= cand;
      max_valid_q <= base_valid || cand_vld;
    end
  end

  assign sr.out_score = out_q.score;
  assign sr.out_id    = out_q.id;
  assign sr.out_lane  = out_lane_q;
  assign sr.out_valid = out_valid_q;
  assign sr.max_score = max_q.score;
  assign sr.max_id    = max_q.id;
  assign sr.max_valid = max_valid_q;
  assign sr.overflow  = overflow_q;
  assign sr.busy      = (|hold_full) || out_valid_q;

endmodule

// File: tb/tb_score_result_collector.sv
// Directed scenarios with hand-derived expectations, then randomized traffic against a transaction-level model.
module tb_score_result_collector;
  localparam int SW = 12;
  localparam int IW = 48;
  localparam int L  = 4;
  localparam int LW = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  score_result_collector_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .LANES(L), .LANE_W(LW)) bus ();

  score_result_collector #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .LANES(L), .LANE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .sr  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lane mailboxes, an output slot and a running query maximum.
  int          m_hs [L];
  longint      m_hi [L];
  bit          m_full [L];
  int          m_rr;
  bit          m_ov;
  int          m_os;
  longint      m_oi;
  int          m_ol;
  bit          m_mv;
  int          m_ms;
  longint      m_mi;
  bit          m_ovf;

  task automatic model_edge();
    int     g;
    int     best;
    int     bs;
    longint bi;
    bit     taken_ok;
    if (!rst) begin
      for (int i = 0; i < L; i++) begin m_full[i] = 0; m_hs[i] = 0; m_hi[i] = 0; end
      m_rr = 0; m_ov = 0; m_os = 0; m_oi = 0; m_ol = 0;
      m_mv = 0; m_ms = 0; m_mi = 0; m_ovf = 0;
      return;
    end
    g = -1;
    if (!m_ov || bus.out_ready) begin
      for (int k = 0; k < L; k++)
        if (g < 0 && m_full[(m_rr + k) % L]) g = (m_rr + k) % L;
      if (g >= 0) begin
        m_os = m_hs[g]; m_oi = m_hi[g]; m_ol = g; m_ov = 1;
        m_full[g] = 0; m_rr = (g + 1) % L;
      end else begin
        m_ov = 0;
      end
    end
    best = -1; bs = 0; bi = 0;
    for (int i = 0; i < L; i++) begin
      if (bus.vld_in[i]) begin
        taken_ok = !m_full[i];
        if (taken_ok) begin
          m_full[i] = 1;
          m_hs[i] = int'(bus.res_in[i*SW +: SW]);
          m_hi[i] = longint'(bus.id_in[i*IW +: IW]);
          if (best < 0 || m_hs[i] > bs) begin best = i; bs = m_hs[i]; bi = m_hi[i]; end
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (bus.clear_max) m_mv = 0;
    if (best >= 0 && (!m_mv || bs > m_ms)) begin m_ms = bs; m_mi = bi; end
    if (best >= 0) m_mv = 1;
  endtask

  task automatic set_lane(input int i, input int score, input longint id);
    bus.res_in[i*SW +: SW] = SW'(score);
    bus.id_in[i*IW +: IW]  = IW'(id);
  endtask

  task automatic step(input logic [L-1:0] v, input logic rdy, input logic clr);
    bus.vld_in    = v;
    bus.out_ready = rdy;
    bus.clear_max = clr;
    @(posedge clk);
    model_edge();
    #1;
    bus.vld_in    = '0;
    bus.clear_max = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step('0, 1'b1, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.overflow, bus.max_valid} !== 4'b0 ||
        bus.out_score !== '0 || bus.out_id !== '0 || bus.out_lane !== '0 ||
        bus.max_score !== '0 || bus.max_id !== '0)
      $display("FAIL reset_state: ov=%b busy=%b ovf=%b mv=%b os=%h oid=%h ol=%0d ms=%h mid=%h, want all 0",
               bus.out_valid, bus.busy, bus.overflow, bus.max_valid, bus.out_score, bus.out_id,
               bus.out_lane, bus.max_score, bus.max_id);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    set_lane(0, 'h812, 'hA5);
    step(4'b0001, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.max_valid !== 1'b1 || bus.max_score !== 12'h812 || bus.max_id !== 48'hA5)
      $display("FAIL single_after_e0: ov=%b mv=%b ms=%h mid=%h, want ov=0 mv=1 ms=812 mid=a5",
               bus.out_valid, bus.max_valid, bus.max_score, bus.max_id);
    else n_pass++;
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_score !== 12'h812 || bus.out_id !== 48'hA5 || bus.out_lane !== 2'd0)
      $display("FAIL single_after_e1: ov=%b os=%h oid=%h ol=%0d, want ov=1 os=812 oid=a5 ol=0",
               bus.out_valid, bus.out_score, bus.out_id, bus.out_lane);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < L; i++) set_lane(i, 'h100 + i, 'h40 + i);
    step(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < L; k++) begin
      step('0, 1'b1, 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_lane !== LW'(k) || bus.out_score !== SW'('h100 + k))
        $display("FAIL burst_order_%0d: ov=%b ol=%0d os=%h, want ov=1 ol=%0d os=%h",
                 k, bus.out_valid, bus.out_lane, bus.out_score, k, 'h100 + k);
      else n_pass++;
    end
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL burst_drain: ov=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
    else n_pass++;
    set_lane(0, 'h200, 'h50);
    set_lane(2, 'h202, 'h52);
    step(4'b0101, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'd0 || bus.out_score !== 12'h200)
      $display("FAIL pair_first: ov=%b ol=%0d os=%h, want 1 0 200", bus.out_valid, bus.out_lane, bus.out_score);
    else n_pass++;
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'd2 || bus.out_score !== 12'h202)
      $display("FAIL pair_second: ov=%b ol=%0d os=%h, want 1 2 202", bus.out_valid, bus.out_lane, bus.out_score);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lane(1, 'hA01, 'h111);
    step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    set_lane(1, 'hB02, 'h222);
    step(4'b0010, 1'b0, 1'b0);
    set_lane(1, 'hC03, 'h333);
    step(4'b0010, 1'b0, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1)
      $display("FAIL bp_overflow: overflow=%b, want 1", bus.overflow);
    else n_pass++;
    for (int k = 0; k < 2; k++) step('0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_score !== 12'hA01 || bus.out_id !== 48'h111 ||
        bus.out_lane !== 2'd1 || bus.busy !== 1'b1)
      $display("FAIL bp_stable: ov=%b os=%h oid=%h ol=%0d busy=%b, want 1 a01 111 1 1",
               bus.out_valid, bus.out_score, bus.out_id, bus.out_lane, bus.busy);
    else n_pass++;
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_score !== 12'hB02 || bus.out_id !== 48'h222)
      $display("FAIL bp_second: ov=%b os=%h oid=%h, want 1 b02 222", bus.out_valid, bus.out_score, bus.out_id);
    else n_pass++;
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL bp_drained: ov=%b ovf=%b busy=%b, want 0 1 0", bus.out_valid, bus.overflow, bus.busy);
    else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    set_lane(2, 'h321, 'h71);
    step(4'b0100, 1'b1, 1'b0);
    set_lane(2, 'h654, 'h72);
    step(4'b0100, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_score !== 12'h321 || bus.out_lane !== 2'd2)
      $display("FAIL coll_old: ov=%b os=%h ol=%0d, want 1 321 2", bus.out_valid, bus.out_score, bus.out_lane);
    else n_pass++;
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_score !== 12'h654 || bus.out_id !== 48'h72 || bus.overflow !== 1'b0)
      $display("FAIL coll_new: ov=%b os=%h oid=%h ovf=%b, want 1 654 72 0",
               bus.out_valid, bus.out_score, bus.out_id, bus.overflow);
    else n_pass++;
  endtask

  task automatic test_max();
    do_reset();
    set_lane(3, 'h900, 'h3333);
    set_lane(1, 'h900, 'h1111);
    step(4'b1010, 1'b1, 1'b0);
    n_checks++;
    if (bus.max_score !== 12'h900 || bus.max_id !== 48'h1111 || bus.max_valid !== 1'b1)
      $display("FAIL max_tie: ms=%h mid=%h mv=%b, want 900 1111 1", bus.max_score, bus.max_id, bus.max_valid);
    else n_pass++;
    set_lane(0, 'h8FF, 'h0F0F);
    step(4'b0001, 1'b1, 1'b0);
    n_checks++;
    if (bus.max_score !== 12'h900 || bus.max_id !== 48'h1111)
      $display("FAIL max_keep: ms=%h mid=%h, want 900 1111", bus.max_score, bus.max_id);
    else n_pass++;
    set_lane(2, 'h805, 'h2222);
    step(4'b0100, 1'b1, 1'b1);
    n_checks++;
    if (bus.max_score !== 12'h805 || bus.max_id !== 48'h2222 || bus.max_valid !== 1'b1)
      $display("FAIL max_clear_cap: ms=%h mid=%h mv=%b, want 805 2222 1", bus.max_score, bus.max_id, bus.max_valid);
    else n_pass++;
    step('0, 1'b1, 1'b1);
    n_checks++;
    if (bus.max_valid !== 1'b0)
      $display("FAIL max_clear: mv=%b, want 0", bus.max_valid);
    else n_pass++;
    set_lane(0, 'h001, 'h9);
    step(4'b0001, 1'b1, 1'b0);
    n_checks++;
    if (bus.max_score !== 12'h001 || bus.max_valid !== 1'b1)
      $display("FAIL max_first_after_clear: ms=%h mv=%b, want 001 1", bus.max_score, bus.max_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < L; i++) set_lane(i, 'h700 + i, 'h900 + i);
    step(4'b1111, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.overflow !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL mid_pre: ov=%b ovf=%b busy=%b, want 1 1 1", bus.out_valid, bus.overflow, bus.busy);
    else n_pass++;
    rst = 1'b0;
    step(4'b1111, 1'b1, 1'b0);
    rst = 1'b1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.overflow, bus.max_valid} !== 4'b0 ||
        bus.out_score !== '0 || bus.out_id !== '0 || bus.out_lane !== '0 || bus.max_score !== '0)
      $display("FAIL mid_reset: ov=%b busy=%b ovf=%b mv=%b os=%h oid=%h ol=%0d ms=%h, want all 0",
               bus.out_valid, bus.busy, bus.overflow, bus.max_valid, bus.out_score, bus.out_id,
               bus.out_lane, bus.max_score);
    else n_pass++;
    set_lane(2, 'h432, 'h77);
    step(4'b0100, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'd2 || bus.out_score !== 12'h432)
      $display("FAIL mid_after: ov=%b ol=%0d os=%h, want 1 2 432", bus.out_valid, bus.out_lane, bus.out_score);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      logic [L-1:0] v;
      for (int i = 0; i < L; i++) set_lane(i, int'($urandom_range(0, 4095)), {$urandom, $urandom});
      v = L'($urandom) & L'($urandom);
      step(v, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      n_checks++;
      if (bus.out_valid !== m_ov || (m_ov && (bus.out_score !== SW'(m_os) || bus.out_id !== IW'(m_oi) ||
          bus.out_lane !== LW'(m_ol)))) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_out cyc %0d: ov=%b os=%h oid=%h ol=%0d, want ov=%b os=%h oid=%h ol=%0d",
                   c, bus.out_valid, bus.out_score, bus.out_id, bus.out_lane, m_ov, m_os, m_oi, m_ol);
      end else n_pass++;
      n_checks++;
      if (bus.max_valid !== m_mv || (m_mv && (bus.max_score !== SW'(m_ms) || bus.max_id !== IW'(m_mi)))) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_max cyc %0d: mv=%b ms=%h mid=%h, want mv=%b ms=%h mid=%h",
                   c, bus.max_valid, bus.max_score, bus.max_id, m_mv, m_ms, m_mi);
      end else n_pass++;
      n_checks++;
      if (bus.overflow !== m_ovf || bus.busy !== (m_ov || m_full[0] || m_full[1] || m_full[2] || m_full[3])) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_status cyc %0d: ovf=%b busy=%b, want ovf=%b ov=%b full=%b%b%b%b",
                   c, bus.overflow, bus.busy, m_ovf, m_ov, m_full[3], m_full[2], m_full[1], m_full[0]);
      end else n_pass++;
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.res_in    = '0;
    bus.id_in     = '0;
    bus.vld_in    = '0;
    bus.clear_max = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_max();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
